// File: rtl/counting.sv
// -----------------------------------------------------------------------------
// counting
//   Moore FSM that detects runs of the form 1+ 2+ 3+ on a 2-bit symbol stream
//   (one symbol per clock), plus a saturating tally of completed patterns.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset (clears state and counter)
//   num        : input symbol 0..3, sampled every rising edge
//   ans        : high while the FSM sits in S123 (trailing run of 3s)
//   match_cnt  : completed patterns since reset, holds at all-ones
// -----------------------------------------------------------------------------
module counting #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       num,
  output logic             ans,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S12  = 2'd2,
    S123 = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             complete_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode on the sampled symbol
  always_comb begin
    state_next_s = IDLE;
    case (num)
      2'd0: state_next_s = IDLE;
      2'd1: state_next_s = S1;   // a 1 always (re)starts a pattern
      2'd2: begin
        if ((state_r == S1) || (state_r == S12)) begin
          state_next_s = S12;
        end else begin
          state_next_s = IDLE;
        end
      end
      2'd3: begin
        if ((state_r == S12) || (state_r == S123)) begin
          state_next_s = S123;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // A pattern completes only on the S12 -> S123 step, not on every 3
  always_comb begin
    complete_s = 1'b0;
    if ((state_r == S12) && (num == 2'd3)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
  end

  // Saturating completed-pattern counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (complete_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Moore output straight from the state register, so it cannot glitch
  always_comb begin
    ans       = (state_r == S123);
    match_cnt = cnt_r;
  end

endmodule

// File: tb/tb_counting.sv
// -----------------------------------------------------------------------------
// tb_counting
//   Self-checking bench for counting. Two instances share the stimulus: one
//   with the default 8-bit counter and one with CNT_W=2 to exercise saturation.
//   Symbols are driven on the falling edge; expectations are queued when a
//   symbol is driven and compared 1 time unit after the sampling rising edge.
// -----------------------------------------------------------------------------
module tb_counting;

  logic       clk;
  logic       rst_n;
  logic [1:0] num;
  logic       ans;
  logic [7:0] match_cnt;
  logic       ans_sat;
  logic [1:0] sat_cnt;

  counting #(.CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .ans       (ans),
    .match_cnt (match_cnt)
  );

  counting #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .num       (num),
    .ans       (ans_sat),
    .match_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic exp_ans;
    int   exp_cnt;
  } exp_t;

  typedef struct {
    bit         rst_before;
    logic [1:0] num;
    logic       exp_ans;
    int         exp_cnt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int sat2(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  function automatic void add(input bit r, input logic [1:0] n, input logic a, input int c);
    vec_t v;
    v.rst_before = r;
    v.num        = n;
    v.exp_ans    = a;
    v.exp_cnt    = c;
    vecs.push_back(v);
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ea, input int ec);
    check_val({tag, " ans"}, {31'd0, ans}, {31'd0, ea});
    check_val({tag, " match_cnt"}, {24'd0, match_cnt}, ec);
    check_val({tag, " sat_ans"}, {31'd0, ans_sat}, {31'd0, ea});
    check_val({tag, " sat_cnt"}, {30'd0, sat_cnt}, sat2(ec));
  endtask

  // Drive one symbol midway between edges, then score the post-edge outputs
  task automatic apply(input logic [1:0] n, input logic ea, input int ec, input string tag);
    exp_t e;
    @(negedge clk);
    num       = n;
    e.exp_ans = ea;
    e.exp_cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard: got empty queue expected 1 entry", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e.exp_ans, e.exp_cnt);
    end
  endtask

  // Reset pulse between clock edges; outputs must clear with no edge
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs(tag, 1'b0, 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    num   = 2'd0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async", 1'b0, 0);

    // Reset held: symbols must have no effect
    apply(2'd1, 1'b0, 0, "rst_hold1");
    apply(2'd2, 1'b0, 0, "rst_hold2");
    apply(2'd3, 1'b0, 0, "rst_hold3");
    rst_n = 1'b1;
    apply(2'd0, 1'b0, 0, "rel0a");
    apply(2'd0, 1'b0, 0, "rel0b");
    apply(2'd2, 1'b0, 0, "idle2");
    apply(2'd3, 1'b0, 0, "idle3");

    // Basic stream 1,1,2,3,3,1,2,1,1,1,2,2,3,3,3,1
    add(1'b0, 2'd1, 1'b0, 0);
    add(1'b0, 2'd1, 1'b0, 0);
    add(1'b0, 2'd2, 1'b0, 0);
    add(1'b0, 2'd3, 1'b1, 1);
    add(1'b0, 2'd3, 1'b1, 1);
    add(1'b0, 2'd1, 1'b0, 1);
    add(1'b0, 2'd2, 1'b0, 1);
    add(1'b0, 2'd1, 1'b0, 1);
    add(1'b0, 2'd1, 1'b0, 1);
    add(1'b0, 2'd1, 1'b0, 1);
    add(1'b0, 2'd2, 1'b0, 1);
    add(1'b0, 2'd2, 1'b0, 1);
    add(1'b0, 2'd3, 1'b1, 2);
    add(1'b0, 2'd3, 1'b1, 2);
    add(1'b0, 2'd3, 1'b1, 2);
    add(1'b0, 2'd1, 1'b0, 2);
    // Broken patterns 1,3,3 / 2,3 / 1,2,0,3
    add(1'b1, 2'd1, 1'b0, 0);
    add(1'b0, 2'd3, 1'b0, 0);
    add(1'b0, 2'd3, 1'b0, 0);
    add(1'b0, 2'd2, 1'b0, 0);
    add(1'b0, 2'd3, 1'b0, 0);
    add(1'b0, 2'd1, 1'b0, 0);
    add(1'b0, 2'd2, 1'b0, 0);
    add(1'b0, 2'd0, 1'b0, 0);
    add(1'b0, 2'd3, 1'b0, 0);
    // Restart on 1: 1,2,1,2,3 then 0
    add(1'b0, 2'd1, 1'b0, 0);
    add(1'b0, 2'd2, 1'b0, 0);
    add(1'b0, 2'd1, 1'b0, 0);
    add(1'b0, 2'd2, 1'b0, 0);
    add(1'b0, 2'd3, 1'b1, 1);
    add(1'b0, 2'd0, 1'b0, 1);
    // Back-to-back 1,2,3,1,2,3
    add(1'b0, 2'd1, 1'b0, 1);
    add(1'b0, 2'd2, 1'b0, 1);
    add(1'b0, 2'd3, 1'b1, 2);
    add(1'b0, 2'd1, 1'b0, 2);
    add(1'b0, 2'd2, 1'b0, 2);
    add(1'b0, 2'd3, 1'b1, 3);
    // Mid-run async reset: 1,2,3,3 then reset, then a lone 3 stays IDLE
    add(1'b0, 2'd1, 1'b0, 3);
    add(1'b0, 2'd2, 1'b0, 3);
    add(1'b0, 2'd3, 1'b1, 4);
    add(1'b0, 2'd3, 1'b1, 4);
    add(1'b1, 2'd3, 1'b0, 0);
    // Saturation: five 1,2,3 patterns from reset
    for (int p = 1; p <= 5; p++) begin
      add((p == 1), 2'd1, 1'b0, p - 1);
      add(1'b0, 2'd2, 1'b0, p - 1);
      add(1'b0, 2'd3, 1'b1, p);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) begin
        pulse_reset($sformatf("rst_before_vec%0d", i));
      end
      apply(vecs[i].num, vecs[i].exp_ans, vecs[i].exp_cnt, $sformatf("vec%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
